// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: picks one hazard cause per cycle and drives the register enables.
// Latency: control outputs are combinational in the same cycle; o_state reports the previous cycle's cause.
// Backpressure: a data-memory wait freezes the whole pipeline; other hazards stall only the front end.
module pipeline_hazard_ctrl #(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_ID_rs,
    input  logic [4:0]       i_ID_rt,
    input  logic             i_ID_useRt,
    input  logic             i_ID_isMdu,
    input  logic             i_ID_readsHiLo,
    input  logic             i_EX_memRead,
    input  logic [4:0]       i_EX_rt,
    input  logic             i_EX_branchTaken,
    input  logic             i_IMEM_ready,
    input  logic             i_DMEM_ready,
    output logic             o_PC_we,
    output logic             o_IF_ID_we,
    output logic             o_IF_ID_flush,
    output logic             o_ID_EX_bubble,
    output logic             o_back_we,
    output logic             o_mduBusy,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_stallCnt,
    output logic [CNT_W-1:0] o_flushCnt
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_FREEZE  = 3'd1,
        ST_LOADUSE = 3'd2,
        ST_MDUWAIT = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_IMISS   = 3'd5
    } cause_e;

    localparam logic [7:0]       MDU_LOAD = 8'(MDU_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    cause_e           state_q, state_d;
    logic [7:0]       mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             mdu_wait;

    // Hazard detection and priority resolution: the first matching cause wins.
    always_comb begin
        load_use = i_EX_memRead && (i_EX_rt != 5'd0) &&
                   ((i_EX_rt == i_ID_rs) || (i_ID_useRt && (i_EX_rt == i_ID_rt)));
        mdu_wait = (mdu_cnt_q != 8'd0) && (i_ID_isMdu || i_ID_readsHiLo);
        state_d  = ST_RUN;
        if (!i_DMEM_ready)          state_d = ST_FREEZE;
        else if (i_EX_branchTaken)  state_d = ST_FLUSH;
        else if (load_use)          state_d = ST_LOADUSE;
        else if (mdu_wait)          state_d = ST_MDUWAIT;
        else if (!i_IMEM_ready)     state_d = ST_IMISS;
    end

    // Per-cause enable pattern; reset overrides so fetch restarts from a clean NOP front end.
    always_comb begin
        o_PC_we        = 1'b1;
        o_IF_ID_we     = 1'b1;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_bubble = 1'b0;
        o_back_we      = 1'b1;
        case (state_d)
            ST_FREEZE: begin
                o_PC_we    = 1'b0;
                o_IF_ID_we = 1'b0;
                o_back_we  = 1'b0;
            end
            ST_FLUSH: begin
                o_IF_ID_flush  = 1'b1;
                o_ID_EX_bubble = 1'b1;
            end
            ST_LOADUSE, ST_MDUWAIT: begin
                o_PC_we        = 1'b0;
                o_IF_ID_we     = 1'b0;
                o_ID_EX_bubble = 1'b1;
            end
            ST_IMISS: begin
                o_PC_we       = 1'b0;
                o_IF_ID_flush = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            o_PC_we        = 1'b0;
            o_IF_ID_we     = 1'b1;
            o_IF_ID_flush  = 1'b1;
            o_ID_EX_bubble = 1'b1;
            o_back_we      = 1'b0;
        end
        o_mduBusy  = (mdu_cnt_q != 8'd0) && !rst;
        o_state    = state_q;
        o_stallCnt = stall_cnt_q;
        o_flushCnt = flush_cnt_q;
    end

    // MDU occupancy and saturating performance counters; an MDU op only issues when it leaves ID normally.
    always_comb begin
        mdu_cnt_d   = mdu_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (((state_d == ST_RUN) || (state_d == ST_IMISS)) && i_ID_isMdu)
            mdu_cnt_d = MDU_LOAD;
        else if ((mdu_cnt_q != 8'd0) && (state_d != ST_FREEZE))
            mdu_cnt_d = mdu_cnt_q - 8'd1;
        if ((state_d == ST_FREEZE) || (state_d == ST_LOADUSE) ||
            (state_d == ST_MDUWAIT) || (state_d == ST_IMISS)) begin
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if ((state_d == ST_FLUSH) && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    // State register: records each cycle's cause along with MDU and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            mdu_cnt_q   <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios plus randomized traffic against a cycle model.
// Latency: outputs sampled 1ns after each falling edge, model advanced before the next rising edge.
// Backpressure: memory-ready inputs are randomized to exercise freeze and fetch-miss stalls.
module tb_pipeline_hazard_ctrl;

    localparam int MDU  = 4;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          use_rt, is_mdu, hilo, mem_rd, br, imem, dmem;
    logic          pc_we, ifid_we, ifid_flush, bubble, back_we, busy;
    logic [2:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_mdu, m_stall, m_flush, m_prev;

    pipeline_hazard_ctrl #(.MDU_CYCLES(MDU), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_ID_rs(id_rs), .i_ID_rt(id_rt), .i_ID_useRt(use_rt),
        .i_ID_isMdu(is_mdu), .i_ID_readsHiLo(hilo),
        .i_EX_memRead(mem_rd), .i_EX_rt(ex_rt), .i_EX_branchTaken(br),
        .i_IMEM_ready(imem), .i_DMEM_ready(dmem),
        .o_PC_we(pc_we), .o_IF_ID_we(ifid_we), .o_IF_ID_flush(ifid_flush),
        .o_ID_EX_bubble(bubble), .o_back_we(back_we), .o_mduBusy(busy),
        .o_state(state), .o_stallCnt(stall_cnt), .o_flushCnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic mdu, input logic hl, input logic mr,
                          input logic [4:0] ert, input logic b, input logic im, input logic dm);
        id_rs = rs; id_rt = rt; use_rt = urt; is_mdu = mdu; hilo = hl;
        mem_rd = mr; ex_rt = ert; br = b; imem = im; dmem = dm;
    endtask

    task automatic idle();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    endtask

    // Cause chosen by the priority rules, 0..5
    function automatic int model_cause();
        if (!dmem) return 1;
        if (br) return 4;
        if (mem_rd && ex_rt != 5'd0 && (ex_rt == id_rs || (use_rt && ex_rt == id_rt))) return 2;
        if (m_mdu != 0 && (is_mdu || hilo)) return 3;
        if (!imem) return 5;
        return 0;
    endfunction

    // Enable pattern {PC_we, IF_ID_we, IF_ID_flush, bubble, back_we} for each cause
    function automatic logic [4:0] ctl_of(input int c);
        case (c)
            1:       return 5'b00000;
            2, 3:    return 5'b00011;
            4:       return 5'b11111;
            5:       return 5'b01101;
            default: return 5'b11001;
        endcase
    endfunction

    task automatic compare_now();
        logic [4:0] exp_ctl;
        exp_ctl = rst ? 5'b01110 : ctl_of(model_cause());
        chk("ctl", {pc_we, ifid_we, ifid_flush, bubble, back_we}, exp_ctl);
        chk("busy", busy, (!rst && m_mdu != 0) ? 1 : 0);
        chk("state", state, m_prev);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic pre();
        #1;
        compare_now();
    endtask

    task automatic post();
        int c;
        if (!rst) begin
            c = model_cause();
            if ((c == 0 || c == 5) && is_mdu) m_mdu = MDU;
            else if (m_mdu > 0 && c != 1) m_mdu = m_mdu - 1;
            if (c == 1 || c == 2 || c == 3 || c == 5) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (c == 4) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            m_prev = c;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_mdu = 0; m_stall = 0; m_flush = 0; m_prev = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        pre();
        post();
        pre();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);
        pre();
        chk("rst_pc_we", pc_we, 0);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_back_we", back_we, 0);
        post();
        rst = 1'b0;

        // Load-use on rs
        set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1);
        pre();
        chk("lu_pc_we", pc_we, 0);
        chk("lu_ifid_we", ifid_we, 0);
        chk("lu_bubble", bubble, 1);
        post();
        idle();
        pre();
        chk("lu_state", state, 2);
        chk("lu_stall", stall_cnt, 1);
        post();

        // Load into r0 never stalls
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        pre();
        chk("r0_pc_we", pc_we, 1);
        chk("r0_bubble", bubble, 0);
        post();

        // Branch beats load-use
        set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1);
        pre();
        chk("br_flush", ifid_flush, 1);
        chk("br_bubble", bubble, 1);
        chk("br_pc_we", pc_we, 1);
        post();
        idle();
        pre();
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 1);
        chk("br_state", state, 4);
        post();

        // MDU issue, then mfhi waits for the counter to drain
        set_in(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        pre();
        chk("mdu_issue_pc", pc_we, 1);
        post();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < MDU; k++) begin
            pre();
            chk("mdu_wait_pc", pc_we, 0);
            chk("mdu_wait_busy", busy, 1);
            post();
        end
        pre();
        chk("mdu_done_pc", pc_we, 1);
        chk("mdu_done_busy", busy, 0);
        chk("mdu_done_stall", stall_cnt, 5);
        post();

        // Data-memory wait during MDU wait freezes everything
        set_in(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        pre();
        post();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            pre();
            chk("frz_ctl", {pc_we, ifid_we, ifid_flush, bubble, back_we}, 0);
            chk("frz_busy", busy, 1);
            post();
        end
        dmem = 1'b1;
        pre();
        chk("frz_stall", stall_cnt, 8);
        chk("frz_state", state, 1);
        post();
        for (int k = 0; k < MDU; k++) begin
            pre();
            post();
        end

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(399) == 0) begin
                do_reset();
                post();
            end
            set_in(5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)),
                   ($urandom_range(99) < 15), ($urandom_range(99) < 20), ($urandom_range(99) < 30),
                   5'($urandom_range(3)), ($urandom_range(99) < 10),
                   ($urandom_range(99) < 85), ($urandom_range(99) < 90));
            pre();
            post();
        end

        // Saturate stall counter, then reset mid MDU wait
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 70; k++) begin
            pre();
            post();
        end
        set_in(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        pre();
        post();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        pre();
        post();
        pre();
        chk("sat_stall", stall_cnt, CMAX);
        chk("sat_state", state, 3);
        chk("sat_busy", busy, 1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_state", state, 0);
        chk("arst_pc_we", pc_we, 0);
        compare_now();
        post();
        pre();
        rst = 1'b0;
        idle();
        pre();
        post();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
